expr_frame_ctrl: RTL

//  Frame sequencer and evaluator wrapped around the single-digit expression checker.
//  - Accepts a byte stream through a valid/ready handshake and splits it into frames terminated by ';' (0x3B).
//  - Clears and steps the checker once per accepted byte, evaluates the expression with '*' binding tighter than '+'.
//  - Presents one result per frame through a result handshake. Sits between the UART byte source and the result sink.

---
 rtl/expr_pkg.sv | 23 ++
 rtl/expr_check.sv | 30 +++
 rtl/expr_frame_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/expr_pkg.sv
// Shared constants and state encodings for the expression frame controller
// and its single-digit expression checker.
package expr_pkg;

  localparam logic [7:0] CH_0    = 8'h30;
  localparam logic [7:0] CH_9    = 8'h39;
  localparam logic [7:0] CH_PLUS = 8'h2B;
  localparam logic [7:0] CH_MUL  = 8'h2A;
  localparam logic [7:0] CH_TERM = 8'h3B;

  typedef enum logic [1:0] {START, NUM, OP, ERR} chk_state_t;
  typedef enum logic {ACCEPT, REPORT} ctrl_state_t;
  typedef enum logic {OP_PLUS, OP_MUL} op_t;

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= CH_0) && (c <= CH_9);
  endfunction

  function automatic logic is_op(input logic [7:0] c);
    return (c == CH_PLUS) || (c == CH_MUL);
  endfunction

endpackage

// File: rtl/expr_check.sv
// Grammar checker for digit ((+|*) digit)*; one step per enabled cycle,
// ERR is sticky until cleared.
module expr_check
  import expr_pkg::*;
(
  input  logic       clk,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic [7:0] i_ch,
  output chk_state_t o_state
);

  chk_state_t r_state;

  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_state <= START;
    end else if (i_en) begin
      unique case (r_state)
        START:   r_state <= is_digit(i_ch) ? NUM : ERR;
        NUM:     r_state <= is_op(i_ch)    ? OP  : ERR;
        OP:      r_state <= is_digit(i_ch) ? NUM : ERR;
        default: r_state <= ERR;
      endcase
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/expr_frame_ctrl.sv
// Splits a ';'-terminated byte stream into frames, evaluates each as a
// sum of products of single digits, and hands one result per frame to the sink.
module expr_frame_ctrl
  import expr_pkg::*;
#(
  parameter int VAL_W = 8,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_ok,
  output logic [VAL_W-1:0] res_value,
  output logic [LEN_W-1:0] res_len
);

  localparam logic [LEN_W-1:0] LEN_MAX = '1;

  ctrl_state_t      r_state;
  logic             r_in_ready;
  logic             r_res_valid;
  logic             r_res_ok;
  logic [VAL_W-1:0] r_res_value;
  logic [LEN_W-1:0] r_res_len;
  logic [VAL_W-1:0] r_sum;
  logic [VAL_W-1:0] r_term;
  logic [LEN_W-1:0] r_len;
  op_t              r_op;
  logic             r_ovf;

  chk_state_t       w_chk;
  logic             w_take;
  logic             w_is_term;
  logic             w_chk_clr;
  logic             w_chk_en;
  logic             w_ok;
  logic [VAL_W-1:0] w_d;
  logic [VAL_W-1:0] w_total;

  assign w_take    = in_valid && r_in_ready;
  assign w_is_term = (in_data == CH_TERM);
  assign w_chk_clr = clr || (w_take && w_is_term);
  assign w_chk_en  = w_take && !w_is_term;
  assign w_ok      = (w_chk == NUM) && !r_ovf;
  assign w_total   = r_sum + r_term;
  // ASCII '0'..'9' are 0x30..0x39, so the low nibble is the digit value
  assign w_d       = VAL_W'(in_data[3:0]);

  expr_check u_chk (
    .clk     (clk),
    .i_clr   (w_chk_clr),
    .i_en    (w_chk_en),
    .i_ch    (in_data),
    .o_state (w_chk)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state     <= ACCEPT;
      r_in_ready  <= 1'b1;
      r_res_valid <= 1'b0;
      r_res_ok    <= 1'b0;
      r_res_value <= '0;
      r_res_len   <= '0;
      r_sum       <= '0;
      r_term      <= '0;
      r_len       <= '0;
      r_op        <= OP_PLUS;
      r_ovf       <= 1'b0;
    end else if (r_state == ACCEPT) begin
      if (w_take && w_is_term) begin
        r_res_ok    <= w_ok;
        r_res_value <= w_ok ? w_total : '0;
        r_res_len   <= r_len;
        r_res_valid <= 1'b1;
        r_in_ready  <= 1'b0;
        r_state     <= REPORT;
        r_sum       <= '0;
        r_term      <= '0;
        r_len       <= '0;
        r_op        <= OP_PLUS;
        r_ovf       <= 1'b0;
      end else if (w_take) begin
        if (r_len == LEN_MAX) r_ovf <= 1'b1;
        else                  r_len <= r_len + 1'b1;
        // accumulators follow the bytes blindly; the checker decides legality
        if (is_digit(in_data)) begin
          if (r_op == OP_PLUS) begin
            r_sum  <= r_sum + r_term;
            r_term <= w_d;
          end else begin
            r_term <= r_term * w_d;
          end
        end else if (in_data == CH_PLUS) begin
          r_op <= OP_PLUS;
        end else if (in_data == CH_MUL) begin
          r_op <= OP_MUL;
        end
      end
    end else if (res_ready) begin
      r_res_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_state     <= ACCEPT;
    end
  end

  assign in_ready  = r_in_ready;
  assign res_valid = r_res_valid;
  assign res_ok    = r_res_ok;
  assign res_value = r_res_value;
  assign res_len   = r_res_len;

endmodule
